// File: rtl/banked_input_buffer.sv
// Banked entry buffer: BANKS x DEPTH entries, written all banks at once (wide) or one bank (select).
// Latency: write visible to reads on the next cycle; read data, rd_valid and rd_miss one cycle after rd_req.
// Backpressure: wr_ready drops only in reset or on a flush cycle; reads are never stalled.
module banked_input_buffer #(
  parameter int DATA_W = 32,
  parameter int LANES  = 16,
  parameter int BANKS  = 4,
  parameter int DEPTH  = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            mode,
  input  logic [$clog2(BANKS)-1:0]        bank_sel,
  input  logic                            flush,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic [$clog2(DEPTH)-1:0]        wr_addr,
  input  logic [BANKS*LANES*DATA_W-1:0]   wr_data_wide,
  input  logic [LANES*DATA_W-1:0]         wr_data_sel,
  input  logic                            rd_req,
  input  logic [$clog2(DEPTH)-1:0]        rd_addr,
  output logic                            rd_valid,
  output logic [BANKS*LANES*DATA_W-1:0]   rd_data_wide,
  output logic [LANES*DATA_W-1:0]         rd_data_sel,
  output logic                            rd_miss,
  output logic [BANKS-1:0]                bank_full
);

  localparam int SLICE_W = LANES * DATA_W;
  localparam int WIDE_W  = BANKS * SLICE_W;
  localparam int BSEL_W  = $clog2(BANKS);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Entry storage is never reset: an entry with a clear valid bit reads as zero,
  // so stale contents are unobservable until the entry is rewritten.
  logic [SLICE_W-1:0] mem_q [BANKS][DEPTH];

  // Per-bank entry-valid bits and fill counts.
  logic [DEPTH-1:0]   vld_q [BANKS];
  logic [DEPTH-1:0]   vld_d [BANKS];
  logic [CNT_W-1:0]   cnt_q [BANKS];
  logic [CNT_W-1:0]   cnt_d [BANKS];

  // Write steering.
  logic               wr_fire;
  logic [BANKS-1:0]   bank_we;
  logic [SLICE_W-1:0] bank_wdat [BANKS];

  // Read path: combinational lookup, registered results.
  logic [BANKS-1:0]   rd_hit;
  logic [SLICE_W-1:0] rd_word [BANKS];
  logic [WIDE_W-1:0]  rd_data_wide_d;
  logic [SLICE_W-1:0] rd_data_sel_d;
  logic               rd_miss_d;

  logic               rd_valid_q;
  logic [WIDE_W-1:0]  rd_data_wide_q;
  logic [SLICE_W-1:0] rd_data_sel_q;
  logic               rd_miss_q;

  // Writes are refused while in reset and on a flush cycle (the flush wins).
  assign wr_ready = rst && !flush;
  assign wr_fire  = wr_valid && wr_ready;

  // Pick which banks take this write and what slice each bank sees.
  always_comb begin
    bank_we = '0;
    for (int b = 0; b < BANKS; b++) begin
      bank_wdat[b] = mode ? wr_data_sel : wr_data_wide[b*SLICE_W +: SLICE_W];
      bank_we[b]   = wr_fire && (!mode || (bank_sel == BSEL_W'(b)));
    end
  end

  // Next valid bits and fill counts; a count only moves when a clear entry becomes valid.
  always_comb begin
    for (int b = 0; b < BANKS; b++) begin
      vld_d[b] = vld_q[b];
      cnt_d[b] = cnt_q[b];
      if (flush) begin
        vld_d[b] = '0;
        cnt_d[b] = '0;
      end else if (bank_we[b]) begin
        vld_d[b][wr_addr] = 1'b1;
        if (!vld_q[b][wr_addr]) begin
          cnt_d[b] = cnt_q[b] + CNT_W'(1);
        end
      end
    end
  end

  // Valid bits and fill counts, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int b = 0; b < BANKS; b++) begin
        vld_q[b] <= '0;
        cnt_q[b] <= '0;
      end
    end else begin
      for (int b = 0; b < BANKS; b++) begin
        vld_q[b] <= vld_d[b];
        cnt_q[b] <= cnt_d[b];
      end
    end
  end

  // Entry data write; bank_we already excludes reset and flush cycles.
  always_ff @(posedge clk) begin
    for (int b = 0; b < BANKS; b++) begin
      if (bank_we[b]) begin
        mem_q[b][wr_addr] <= bank_wdat[b];
      end
    end
  end

  // A bank is full once every one of its entries has been written since the last clear.
  always_comb begin
    bank_full = '0;
    for (int b = 0; b < BANKS; b++) begin
      bank_full[b] = (cnt_q[b] == FULL_CNT);
    end
  end

  // Read lookup against pre-write state, which gives read-first behaviour on collisions
  // and makes a read on a flush cycle see the pre-flush contents.
  always_comb begin
    rd_hit         = '0;
    rd_data_wide_d = '0;
    for (int b = 0; b < BANKS; b++) begin
      rd_hit[b]  = vld_q[b][rd_addr];
      rd_word[b] = rd_hit[b] ? mem_q[b][rd_addr] : '0;
      rd_data_wide_d[b*SLICE_W +: SLICE_W] = rd_word[b];
    end
    rd_data_sel_d = rd_word[bank_sel];
    rd_miss_d     = mode ? !rd_hit[bank_sel] : !(&rd_hit);
  end

  // Read result registers: data and miss hold between reads, rd_valid pulses once per read.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_valid_q     <= 1'b0;
      rd_data_wide_q <= '0;
      rd_data_sel_q  <= '0;
      rd_miss_q      <= 1'b0;
    end else begin
      rd_valid_q <= rd_req;
      if (rd_req) begin
        rd_data_wide_q <= rd_data_wide_d;
        rd_data_sel_q  <= rd_data_sel_d;
        rd_miss_q      <= rd_miss_d;
      end
    end
  end

  assign rd_valid     = rd_valid_q;
  assign rd_data_wide = rd_data_wide_q;
  assign rd_data_sel  = rd_data_sel_q;
  assign rd_miss      = rd_miss_q;

endmodule
